chaser_step_ctrl: RTL

Upstream control stage for the dual-colour LED chaser: turns three raw push-buttons into a one-cycle `step` enable that advances the scroll pattern. It replaces the fixed free-running divider tap with a user-selectable speed, pause/run, and manual single-step. It sits between the board buttons and the scroll stage, which advances on `step` while running on the system clock.

---
 rtl/chaser_step_ctrl_if.sv | 24 ++
 rtl/chaser_step_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/chaser_step_ctrl_if.sv
// Button and step bundle for the LED chaser control stage.
//   btn_speed, btn_pause, btn_step : raw active-high push-buttons (asynchronous to clk)
//   step      : one-cycle advance pulse to the scroll stage
//   speed_lvl : current speed level, 0 = fastest, 3 = slowest
//   running   : 1 = RUN, 0 = PAUSE
// master drives the buttons (board side); slave is the controller.
interface chaser_step_ctrl_if;
  logic       btn_speed;
  logic       btn_pause;
  logic       btn_step;
  logic       step;
  logic [1:0] speed_lvl;
  logic       running;

  modport master (
    output btn_speed, btn_pause, btn_step,
    input  step, speed_lvl, running
  );

  modport slave (
    input  btn_speed, btn_pause, btn_step,
    output step, speed_lvl, running
  );
endinterface

// File: rtl/chaser_step_ctrl.sv
// Chaser step control: turns three raw buttons into a one-cycle step enable
// with selectable speed, run/pause and manual single-step.
//   clk   : system clock
//   reset : asynchronous active-high reset
//   bus   : chaser_step_ctrl_if.slave (buttons in; step, speed_lvl, running out)
//
// state  | meaning
// -------+--------------------------------------------------------------
// ST_RUN  | period counter advances, step pulses on expiry, btn_step ignored
// ST_PAUSE| period counter held at 0, btn_step issues one manual step
module chaser_step_ctrl #(
  parameter int DEB_BITS = 16,
  parameter int BASE_EXP = 18
) (
  input logic               clk,
  input logic               reset,
  chaser_step_ctrl_if.slave bus
);

  localparam int CW = BASE_EXP + 3;

  typedef enum logic {
    ST_PAUSE = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // button index: 0 = speed, 1 = pause, 2 = step
  logic [2:0]          raw;
  logic [2:0]          sync1_q;
  logic [2:0]          sync2_q;
  logic [2:0]          deb_q;
  logic [2:0]          deb_d;
  logic [2:0]          deb_prev_q;
  logic [DEB_BITS-1:0] deb_cnt_q [3];
  logic [DEB_BITS-1:0] deb_cnt_d [3];
  logic [2:0]          press;
  logic                ev_speed;
  logic                ev_pause;
  logic                ev_step;

  state_t              state_q;
  state_t              state_d;
  logic [1:0]          speed_q;
  logic [1:0]          speed_d;
  logic [CW-1:0]       per_cnt_q;
  logic [CW-1:0]       per_cnt_d;
  logic [CW-1:0]       per_last;
  logic                step_q;
  logic                step_d;

  assign raw = {bus.btn_step, bus.btn_pause, bus.btn_speed};

  // ---------------------------------------------------------------------
  // Synchronisers and debouncers
  // ---------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      deb_d[i]     = deb_q[i];
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        // accept only after the counter has run all the way to all-ones
        if (&deb_cnt_q[i]) begin
          deb_d[i] = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < 3; i++) begin
        deb_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      for (int i = 0; i < 3; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
      end
    end
  end

  // press = rising edge of the debounced level; releases are ignored
  assign press    = deb_q & ~deb_prev_q;
  assign ev_speed = press[0];
  assign ev_pause = press[1];
  assign ev_step  = press[2];

  // terminal count 2^(BASE_EXP+speed)-1
  assign per_last = (CW'(1) << (BASE_EXP + int'(speed_q))) - CW'(1);

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (ev_pause) begin
      state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: outputs (period counter, speed level, step), registered below
  // ---------------------------------------------------------------------
  always_comb begin
    speed_d   = speed_q;
    per_cnt_d = per_cnt_q;
    step_d    = 1'b0;
    if (ev_speed) begin
      speed_d = speed_q + 2'd1;
    end
    if (state_q == ST_RUN) begin
      // any speed or pause event restarts the period and swallows an expiry
      if (ev_speed || ev_pause) begin
        per_cnt_d = '0;
      end else if (per_cnt_q == per_last) begin
        per_cnt_d = '0;
        step_d    = 1'b1;
      end else begin
        per_cnt_d = per_cnt_q + 1'b1;
      end
    end else begin
      per_cnt_d = '0;
      // a simultaneous pause event resumes instead of stepping
      step_d    = ev_step && !ev_pause;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      speed_q   <= '0;
      per_cnt_q <= '0;
      step_q    <= 1'b0;
    end else begin
      speed_q   <= speed_d;
      per_cnt_q <= per_cnt_d;
      step_q    <= step_d;
    end
  end

  assign bus.step      = step_q;
  assign bus.speed_lvl = speed_q;
  assign bus.running   = state_q;

endmodule
